// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg -- shared definitions for the pipeline hazard controller.
//   FSM state encoding, the per-cycle event codes (which also fix the event
//   priority), the stage-control bundle and the event -> control decode.
package pipeline_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_STALL  = 2'd1;
  localparam logic [1:0] ST_IMEM_WAIT = 2'd2;
  localparam logic [1:0] ST_DMEM_WAIT = 2'd3;

  // Winning event of a cycle; a higher code means a higher priority.
  localparam logic [2:0] EV_NONE  = 3'd0;  // normal flow
  localparam logic [2:0] EV_DROP  = 3'd1;  // stale fetch returned after a redirect
  localparam logic [2:0] EV_IMEM  = 3'd2;  // fetch not ready
  localparam logic [2:0] EV_LU    = 3'd3;  // load-use stall
  localparam logic [2:0] EV_REDIR = 3'd4;  // branch / jump redirect
  localparam logic [2:0] EV_DMEM  = 3'd5;  // data memory stall

  localparam int WCNT_W = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctl_t;

  // Stage controls for a given winning event.
  function automatic ctl_t ctl_for(input logic [2:0] ev);
    ctl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
          ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
          mem_wb_bubble: 1'b0};
    case (ev)
      EV_DMEM: begin
        c.pc_write      = 1'b0;
        c.if_id_write   = 1'b0;
        c.id_ex_write   = 1'b0;
        c.ex_mem_write  = 1'b0;
        c.mem_wb_bubble = 1'b1;
      end
      EV_REDIR: begin
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      EV_LU: begin
        c.pc_write    = 1'b0;
        c.if_id_write = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      // A dropped stale fetch looks like a fetch stall: PC already holds the
      // redirect target, so it must not advance past it.
      EV_IMEM, EV_DROP: begin
        c.pc_write    = 1'b0;
        c.if_id_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// pipe_perf_cnt -- stall / flush cycle counters for pipeline_ctrl.
//   clk        in   clock
//   rst        in   synchronous active-high clear
//   stall_inc  in   count a stall cycle (pc_write=0, not in reset)
//   flush_inc  in   count a redirect cycle
//   stall_cnt  out  32-bit wrapping stall cycle count
//   flush_cnt  out  32-bit wrapping redirect cycle count
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- 5-stage pipeline hazard / stall controller.
//   Parameter DMEM_TIMEOUT (1..65535): max data-memory stall cycles before abort.
//   Inputs : clk, rst (sync, active-high), load_use_hazard, branch_taken, jump,
//            imem_ready, dmem_req, dmem_ready
//   Outputs: pc_write, if_id_write, id_ex_write, ex_mem_write (stage enables),
//            if_id_flush, id_ex_flush, mem_wb_bubble (bubble controls),
//            dmem_timeout (one-cycle abort pulse)
//   Optional macro PIPE_CTRL_PERF_CNT_EN adds stall_cnt / flush_cnt outputs
//   (32-bit) backed by pipe_perf_cnt.
// Outputs are Mealy: decoded each cycle from registered state plus inputs.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load_use_hazard,
  input  logic branch_taken,
  input  logic jump,
  input  logic imem_ready,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic pc_write,
  output logic if_id_write,
  output logic id_ex_write,
  output logic ex_mem_write,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic mem_wb_bubble,
  output logic dmem_timeout
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // Stall cycle index (zero-based) on which the abort fires.
  localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'(DMEM_TIMEOUT - 1);

  logic [1:0]        state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              discard, discard_nxt;
  logic [2:0]        ev;
  logic              dmem_pend, to_hit;
  ctl_t              ctl;

  always_comb begin
    // Once in DMEM_WAIT the stall holds until ready, even if dmem_req drops.
    dmem_pend = (dmem_req || state == ST_DMEM_WAIT) && !dmem_ready;
    to_hit    = dmem_pend && (wait_cnt == TO_LAST);

    if (dmem_pend)                                      ev = EV_DMEM;
    else if (branch_taken || jump)                      ev = EV_REDIR;
    else if (load_use_hazard && state != ST_LU_STALL)   ev = EV_LU;
    else if (!imem_ready)                               ev = EV_IMEM;
    else if (discard)                                   ev = EV_DROP;
    else                                                ev = EV_NONE;

    state_nxt    = ST_RUN;
    wait_cnt_nxt = '0;
    discard_nxt  = discard;
    case (ev)
      EV_DMEM: begin
        // The abort cycle is still a stall cycle; release happens next cycle.
        state_nxt    = to_hit ? ST_RUN : ST_DMEM_WAIT;
        wait_cnt_nxt = to_hit ? '0 : wait_cnt + 1'b1;
      end
      EV_REDIR: begin
        // A fetch still in flight belongs to the old path and must be dropped
        // when it returns; a fetch landing this cycle is flushed right now.
        state_nxt   = imem_ready ? ST_RUN : ST_IMEM_WAIT;
        discard_nxt = !imem_ready;
      end
      EV_LU:   state_nxt = ST_LU_STALL;
      EV_IMEM: state_nxt = ST_IMEM_WAIT;
      EV_DROP: discard_nxt = 1'b0;
      default: ;
    endcase

    ctl = ctl_for(ev);
    if (rst) begin
      ctl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
              ex_mem_write: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
              mem_wb_bubble: 1'b1};
    end
  end

  assign {pc_write, if_id_write, id_ex_write, ex_mem_write,
          if_id_flush, id_ex_flush, mem_wb_bubble} = ctl;
  assign dmem_timeout = to_hit && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      discard  <= discard_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (!rst && !ctl.pc_write),
    .flush_inc (!rst && ev == EV_REDIR),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl -- directed self-checking bench for pipeline_ctrl.
//   Inputs change 1 time unit after the rising edge; the Mealy outputs are
//   sampled on the falling edge. Output vector order:
//   {pc_write, if_id_write, id_ex_write, ex_mem_write,
//    if_id_flush, id_ex_flush, mem_wb_bubble, dmem_timeout}
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, lu, br, jmp, imr, dreq, drdy;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, dmem_timeout;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.DMEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use_hazard (lu),
    .branch_taken    (br),
    .jump            (jmp),
    .imem_ready      (imr),
    .dmem_req        (dreq),
    .dmem_ready      (drdy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .dmem_timeout    (dmem_timeout)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  logic [7:0] outs;
  assign outs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, mem_wb_bubble, dmem_timeout};

  localparam logic [7:0] O_RST   = 8'b0000_1110;
  localparam logic [7:0] O_NORM  = 8'b1111_0000;
  localparam logic [7:0] O_DST   = 8'b0000_0010;
  localparam logic [7:0] O_DTO   = 8'b0000_0011;
  localparam logic [7:0] O_REDIR = 8'b1111_1100;
  localparam logic [7:0] O_LU    = 8'b0011_0100;
  localparam logic [7:0] O_IMEM  = 8'b0111_1000;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, commit on the edge.
  task automatic cyc(input string tag, input logic r, input logic l, input logic b,
                     input logic j, input logic im, input logic dq, input logic dr,
                     input logic [7:0] exp);
    rst = r; lu = l; br = b; jmp = j; imr = im; dreq = dq; drdy = dr;
    @(negedge clk);
    chk(tag, {24'd0, outs}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; lu = 1'b0; br = 1'b0; jmp = 1'b0; imr = 1'b1; dreq = 1'b0; drdy = 1'b0;
    @(posedge clk);
    #1;

    //             tag          rst lu br jmp imr dq dr  expected
    cyc("rst",         1, 1, 1, 0, 0, 1, 0, O_RST);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif

    // dmem wait: three stall cycles then ready
    cyc("dm_w1",       0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("dm_w2",       0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("dm_w3",       0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("dm_rdy",      0, 0, 0, 0, 1, 1, 1, O_NORM);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("dm_stall_cnt", stall_cnt, 32'd3);
    chk("dm_flush_cnt", flush_cnt, 32'd0);
`endif

    // load-use: one stall, hazard masked on the next cycle
    cyc("lu",          0, 1, 0, 0, 1, 0, 0, O_LU);
    cyc("lu_mask",     0, 1, 0, 0, 1, 0, 0, O_NORM);
    cyc("lu_done",     0, 0, 0, 0, 1, 0, 0, O_NORM);

    // branch + load-use in the same cycle: redirect wins, no LU_STALL entered
    cyc("rst2",        1, 0, 0, 0, 1, 0, 0, O_RST);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("rst2_stall_cnt", stall_cnt, 32'd0);
`endif
    cyc("br_lu",       0, 1, 1, 0, 1, 0, 0, O_REDIR);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("br_flush_cnt", flush_cnt, 32'd1);
`endif
    cyc("br_no_lus",   0, 1, 0, 0, 1, 0, 0, O_LU);
    cyc("br_after",    0, 0, 0, 0, 1, 0, 0, O_NORM);
    cyc("jmp",         0, 0, 0, 1, 1, 0, 0, O_REDIR);

    // timeout with DMEM_TIMEOUT=4, then a fresh stall proves the counter cleared
    cyc("to_1",        0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("to_2",        0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("to_3",        0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("to_4",        0, 0, 0, 0, 1, 1, 0, O_DTO);
    cyc("to_rel",      0, 0, 0, 0, 1, 0, 0, O_NORM);
    cyc("to_clr",      0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("to_rdy",      0, 0, 0, 0, 1, 1, 1, O_NORM);

    // redirect while fetch outstanding: stale fetch dropped once
    cyc("im_br",       0, 0, 1, 0, 0, 0, 0, O_REDIR);
    cyc("im_wait",     0, 0, 0, 0, 0, 0, 0, O_IMEM);
    cyc("im_drop",     0, 0, 0, 0, 1, 0, 0, O_IMEM);
    cyc("im_norm",     0, 0, 0, 0, 1, 0, 0, O_NORM);

    // plain fetch stall: no drop on return
    cyc("im2_wait",    0, 0, 0, 0, 0, 0, 0, O_IMEM);
    cyc("im2_rdy",     0, 0, 0, 0, 1, 0, 0, O_NORM);

    // dmem stall outranks redirect and load-use
    cyc("dm_br",       0, 1, 1, 0, 1, 1, 0, O_DST);
    cyc("dm_br_rdy",   0, 0, 0, 0, 1, 1, 1, O_NORM);

    // reset abandons a dmem stall and a load-use stall
    cyc("rs_dm",       0, 0, 0, 0, 1, 1, 0, O_DST);
    cyc("rs_rst",      1, 0, 0, 0, 1, 1, 0, O_RST);
    cyc("rs_run",      0, 0, 0, 0, 1, 0, 0, O_NORM);
    cyc("rs_lu",       0, 1, 0, 0, 1, 0, 0, O_LU);
    cyc("rs_rst2",     1, 1, 0, 0, 1, 0, 0, O_RST);
    cyc("rs_lu2",      0, 1, 0, 0, 1, 0, 0, O_LU);

    cyc("rst3",        1, 0, 0, 0, 1, 0, 0, O_RST);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("rst3_stall_cnt", stall_cnt, 32'd0);
    chk("rst3_flush_cnt", flush_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
